// File: rtl/alu_exec_stage_pkg.sv
// Shared encodings for the execute stage: ALU function codes, condition-code
// layout and the queue occupancy states.
package alu_exec_stage_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    // Y86 power-on condition codes: zero flag set, sign and overflow clear.
    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_e;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Decode-side request, memory-side result and condition-code signals of the
// execute stage; the stage itself takes the slave view.
interface alu_exec_stage_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_ifun;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_set_cc;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_e;
    logic             out_overflow;

    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;

    modport master (
        output in_valid, in_ifun, in_a, in_b, in_set_cc, out_ready,
        input  in_ready, out_valid, out_e, out_overflow, cc_zf, cc_sf, cc_of
    );

    modport slave (
        input  in_valid, in_ifun, in_a, in_b, in_set_cc, out_ready,
        output in_ready, out_valid, out_e, out_overflow, cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/alu_exec_stage_alu64.sv
// Combinational ALU: valE and signed overflow for add/sub/and/xor.
// Subtraction is b - a, matching the Y86 operand order.
module alu64
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  alu_op_e          ifun,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] e,
    output logic             overflow
);
    logic sign_a;
    logic sign_b;

    assign sign_a = a[WIDTH-1];
    assign sign_b = b[WIDTH-1];

    always_comb begin
        e        = '0;
        overflow = 1'b0;
        unique case (ifun)
            ALU_ADD: begin
                e        = b + a;
                overflow = (sign_a == sign_b) && (e[WIDTH-1] != sign_a);
            end
            ALU_SUB: begin
                e        = b - a;
                overflow = (sign_a != sign_b) && (e[WIDTH-1] != sign_b);
            end
            ALU_AND: e = a & b;
            ALU_XOR: e = a ^ b;
            default: begin
                e        = '0;
                overflow = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU result and overflow enter a 1- or 2-entry output queue
// with one-cycle latency; condition codes update at the accepting edge.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input logic              clk,
    input logic              rst_n,
    alu_exec_stage_if.slave  bus
);
    typedef struct packed {
        logic [WIDTH-1:0] e;
        logic             ovf;
    } entry_t;

    occ_e             occ_q;
    occ_e             occ_d;
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    cc_t              cc_q;
    entry_t [DEPTH-1:0] entries;
    entry_t           head;

    logic [WIDTH-1:0] alu_e;
    logic             alu_ovf;
    logic             out_valid;
    logic             in_ready;
    logic             enq;
    logic             deq;

    function automatic logic ptr_inc(input logic p);
        return (DEPTH == 1) ? 1'b0 : ~p;
    endfunction

    alu64 #(.WIDTH(WIDTH)) u_alu (
        .ifun     (alu_op_e'(bus.in_ifun)),
        .a        (bus.in_a),
        .b        (bus.in_b),
        .e        (alu_e),
        .overflow (alu_ovf)
    );

    // A full queue can still accept when its head leaves in the same cycle.
    assign out_valid = (occ_q != OCC_EMPTY);
    assign in_ready  = rst_n && ((occ_q != OCC_FULL) || bus.out_ready);
    assign enq       = bus.in_valid && in_ready;
    assign deq       = out_valid && bus.out_ready;

    always_comb begin
        occ_d = occ_q;
        if (enq && !deq) begin
            unique case (occ_q)
                OCC_EMPTY: occ_d = (DEPTH == 1) ? OCC_FULL : OCC_ONE;
                OCC_ONE:   occ_d = OCC_FULL;
                default:   occ_d = occ_q;
            endcase
        end else if (deq && !enq) begin
            unique case (occ_q)
                OCC_FULL: occ_d = (DEPTH == 1) ? OCC_EMPTY : OCC_ONE;
                OCC_ONE:  occ_d = OCC_EMPTY;
                default:  occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q    <= OCC_EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cc_q     <= CC_RESET;
        end else begin
            occ_q <= occ_d;
            if (enq) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (deq) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (enq && bus.in_set_cc) begin
                cc_q <= '{zf: (alu_e == '0), sf: alu_e[WIDTH-1], of: alu_ovf};
            end
        end
    end

    // Entries are cleared on reset so the head reads back as zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        entry_t entry_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                entry_q <= '0;
            end else if (enq && (wr_ptr_q == 1'(gi))) begin
                entry_q <= '{e: alu_e, ovf: alu_ovf};
            end
        end

        assign entries[gi] = entry_q;
    end

    assign head = entries[rd_ptr_q];

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_e        = head.e;
    assign bus.out_overflow = head.ovf;
    assign bus.cc_zf        = cc_q.zf;
    assign bus.cc_sf        = cc_q.sf;
    assign bus.cc_of        = cc_q.of;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: arithmetic vectors, backpressure,
// reset with a full queue and back-to-back streaming.
module tb_alu_exec_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    alu_exec_stage_if #(.WIDTH(64)) bus ();

    alu_exec_stage #(.WIDTH(64), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic offer(input logic v, input logic [1:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic sc);
        bus.in_valid  = v;
        bus.in_ifun   = f;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_set_cc = sc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        offer(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready_low: got %b want 0", bus.in_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready_high: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_e !== 64'd0) begin fails++; $display("FAIL rst_out_e: got %h want 0", bus.out_e); end
        checks++; if (bus.out_overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b want 0", bus.out_overflow); end
        checks++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b100) begin fails++; $display("FAIL rst_cc: got %b want 100", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
        $display("reset: cc=%b in_ready=%b", {bus.cc_zf, bus.cc_sf, bus.cc_of}, bus.in_ready);
    endtask

    task automatic test_arith();
        logic [1:0]  f  [6] = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b00};
        logic [63:0] a  [6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 64'd5,
                                64'd1, 64'h0000_0000_0000_F0F0, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] b  [6] = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5,
                                64'h8000_0000_0000_0000, 64'h0000_0000_0000_FF00, 64'd1};
        logic        sc [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [63:0] ee [6] = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_000E, 64'd0,
                                64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_F000, 64'd0};
        logic        eo [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  ec [6] = '{3'b011, 3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL arith%0d_idle: out_valid got %b want 0", i, bus.out_valid); end
            offer(1'b1, f[i], a[i], b[i], sc[i]);
            @(posedge clk);
            @(negedge clk);
            offer(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
            #1;
            checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL arith%0d_valid: got %b want 1", i, bus.out_valid); end
            checks++; if (bus.out_e !== ee[i]) begin fails++; $display("FAIL arith%0d_e: got %h want %h", i, bus.out_e, ee[i]); end
            checks++; if (bus.out_overflow !== eo[i]) begin fails++; $display("FAIL arith%0d_ovf: got %b want %b", i, bus.out_overflow, eo[i]); end
            checks++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== ec[i]) begin fails++; $display("FAIL arith%0d_cc: got %b want %b", i, {bus.cc_zf, bus.cc_sf, bus.cc_of}, ec[i]); end
            $display("arith %0d: ifun=%0d e=%h ovf=%b cc=%b", i, f[i], bus.out_e, bus.out_overflow, {bus.cc_zf, bus.cc_sf, bus.cc_of});
            @(posedge clk);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.out_ready = 1'b0;
        offer(1'b1, 2'b00, 64'd1, 64'd10, 1'b1);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_op1_ready: got %b want 1", bus.in_ready); end
        @(posedge clk);
        @(negedge clk);
        offer(1'b1, 2'b01, 64'd3, 64'd10, 1'b0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_op2_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_e !== 64'd11) begin fails++; $display("FAIL bp_head1: got %h want 11", bus.out_e); end
        checks++; if (bus.cc_zf !== 1'b0) begin fails++; $display("FAIL bp_cc_under_backpressure: zf got %b want 0", bus.cc_zf); end
        @(posedge clk);
        @(negedge clk);
        offer(1'b1, 2'b11, 64'h55, 64'h55, 1'b1);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready_hold: got %b want 0", bus.in_ready); end
        checks++; if (bus.cc_zf !== 1'b0) begin fails++; $display("FAIL bp_refused_cc: zf got %b want 0", bus.cc_zf); end
        checks++; if (bus.out_e !== 64'd11) begin fails++; $display("FAIL bp_head_hold: got %h want 11", bus.out_e); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_pass_through_ready: got %b want 1", bus.in_ready); end
        @(posedge clk);
        @(negedge clk);
        offer(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
        #1;
        checks++; if (bus.out_e !== 64'd7) begin fails++; $display("FAIL bp_head2: got %h want 7", bus.out_e); end
        checks++; if (bus.cc_zf !== 1'b1) begin fails++; $display("FAIL bp_op3_cc: zf got %b want 1", bus.cc_zf); end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if ({bus.out_valid, bus.out_e} !== {1'b1, 64'd0}) begin fails++; $display("FAIL bp_head3: got %b/%h want 1/0", bus.out_valid, bus.out_e); end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b want 0", bus.out_valid); end
        $display("backpressure: three ops drained, cc=%b", {bus.cc_zf, bus.cc_sf, bus.cc_of});
    endtask

    task automatic test_reset_full();
        @(negedge clk);
        bus.out_ready = 1'b0;
        offer(1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        offer(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
        #1;
        checks++; if ({bus.in_ready, bus.cc_sf} !== 2'b01) begin fails++; $display("FAIL rf_full: ready/sf got %b want 01", {bus.in_ready, bus.cc_sf}); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rf_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_e !== 64'd0) begin fails++; $display("FAIL rf_out_e: got %h want 0", bus.out_e); end
        checks++; if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b100) begin fails++; $display("FAIL rf_cc: got %b want 100", {bus.cc_zf, bus.cc_sf, bus.cc_of}); end
        checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rf_ready_in_reset: got %b want 0", bus.in_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rf_ready_after: got %b want 1", bus.in_ready); end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rf_no_residue: got %b want 0", bus.out_valid); end
        $display("reset_full: queue flushed, cc=%b", {bus.cc_zf, bus.cc_sf, bus.cc_of});
    endtask

    task automatic test_back_to_back();
        logic [1:0]  f  [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        logic [63:0] a  [6] = '{64'hFF00, 64'd3, 64'hAAAA, 64'd2, 64'h1234, 64'd0};
        logic [63:0] b  [6] = '{64'h0FF0, 64'h10, 64'hFFFF, 64'd1, 64'h00FF, 64'h8000_0000_0000_0000};
        logic [63:0] ee [6] = '{64'h0F00, 64'h0D, 64'hAAAA, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0034,
                                64'h8000_0000_0000_0000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            offer(1'b1, f[i], a[i], b[i], 1'b0);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b%0d_ready: got %b want 1", i, bus.in_ready); end
            if (i > 0) begin
                checks++; if ({bus.out_valid, bus.out_e} !== {1'b1, ee[i-1]}) begin fails++; $display("FAIL b2b%0d_e: got %b/%h want 1/%h", i, bus.out_valid, bus.out_e, ee[i-1]); end
                $display("b2b %0d: e=%h", i - 1, bus.out_e);
            end
            @(posedge clk);
        end
        @(negedge clk);
        offer(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
        #1;
        checks++; if ({bus.out_valid, bus.out_e, bus.out_overflow} !== {1'b1, ee[5], 1'b0}) begin fails++; $display("FAIL b2b_last: got %b/%h/%b want 1/%h/0", bus.out_valid, bus.out_e, bus.out_overflow, ee[5]); end
        $display("b2b 5: e=%h", bus.out_e);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %b want 0", bus.out_valid); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_full();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
